uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: first-word-fall-through byte FIFO feeding an oversampled serialiser (8N1).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit before STOP (8E1).
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                        clk,
  input  logic                        Rst,
  input  logic                        baud_tick,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [2:0]                  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;
  logic [7:0]    head;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  // Handshake: a byte is taken on every rising edge where tx_valid and tx_ready are both high;
  // tx_ready depends only on occupancy, so a pop in the same cycle never reopens a full FIFO.
  assign tx_ready   = (count_q != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign bit_end = baud_tick && (tick_q == TICK_LAST);

  // State register
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tick_q    <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tick_q    <= tick_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic; a load restarts the bit timer regardless of baud_tick phase
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tick_d    = tick_q;
    done_d    = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != S_IDLE && baud_tick) tick_d = bit_end ? '0 : tick_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
          shift_d = head;
          tick_d  = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = head;
            tick_d  = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: line level for the state being entered, registered into tx_q
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx          = tx_q;
  assign frame_done  = done_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: frame table, handshake/reset corner sequences,
// and random traffic compared cycle by cycle against a queue-based transaction model.
module tb_uart_tx_engine;

  localparam int DEPTH = 8;
  localparam int OS    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       Rst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [3:0] fifo_count;
  logic [2:0] dbg_state;

  uart_tx_engine #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .frame_done(frame_done),
    .fifo_count(fifo_count), .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt, done_cnt, tick_meas, gaps;

  // Reference model: queued bytes plus the frame currently on the line
  logic [7:0] exp_q[$];
  bit         m_active;
  int         m_ticks, m_bit;
  logic [7:0] m_cur;
  logic       cap [11];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame10;   // line levels, index 0 sent first: start, d0..d7, stop
    logic       par;
  } vec_t;
  vec_t vecs[8];

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (FRAME == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model across the edge, compare all outputs
  task automatic step(input logic v, input logic [7:0] d, input logic tk);
    logic m_ready, m_done;
    tx_valid  = v;
    tx_data   = d;
    baud_tick = tk;
    m_ready   = (exp_q.size() != DEPTH);
    if (busy && tk) tick_meas++;
    if (v && tx_ready) acc_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    m_done = 1'b0;
    if (m_active && tk) begin
      m_ticks++;
      if (m_ticks == OS) begin
        m_ticks = 0;
        m_bit++;
        if (m_bit == FRAME) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end
    if (!m_active && exp_q.size() != 0) begin
      m_cur    = exp_q.pop_front();
      m_active = 1'b1;
      m_bit    = 0;
      m_ticks  = 0;
    end
    if (v && m_ready) exp_q.push_back(d);
    chk("tx", tx, m_active ? frame_bit(m_cur, m_bit) : 1'b1);
    chk("busy", busy, m_active);
    chk("frame_done", frame_done, m_done);
    chk("fifo_count", fifo_count, exp_q.size());
    chk("tx_ready", tx_ready, exp_q.size() != DEPTH);
    if (frame_done) done_cnt++;
    if (m_active && m_ticks == OS / 2) cap[m_bit] = tx;
  endtask

  // Reset: asserted between edges, outputs checked before any clock edge
  task automatic apply_reset();
    Rst       = 1'b1;
    tx_valid  = 1'b0;
    baud_tick = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    @(posedge clk);
    #1;
    Rst = 1'b0;
    exp_q.delete();
    m_active = 1'b0;
    m_ticks  = 0;
    m_bit    = 0;
  endtask

  initial begin
    logic e;
    Rst = 1'b0; tx_valid = 1'b0; baud_tick = 1'b0; tx_data = '0;
    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[5] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[6] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[7] = '{8'h5A, 10'b1_01011010_0, 1'b0};
    #2;
    apply_reset();

    // Frame table: single byte, baud_tick every 4 clks
    foreach (vecs[k]) begin
      for (int i = 0; i < 11; i++) cap[i] = 1'bx;
      tick_meas = 0;
      done_cnt  = 0;
      step(1'b1, vecs[k].data, 1'b0);
      for (int n = 0; n < 4000 && done_cnt == 0; n++) step(1'b0, 8'h00, (cyc % 4) == 0);
      repeat (8) step(1'b0, 8'h00, (cyc % 4) == 0);
      chk("table_done_pulses", done_cnt, 1);
      chk("table_frame_ticks", tick_meas, OS * FRAME);
      for (int i = 0; i < FRAME; i++) begin
        e = (i < 9) ? vecs[k].frame10[i] : (i == FRAME - 1) ? vecs[k].frame10[9] : vecs[k].par;
        chk($sformatf("table_%02h_bit%0d", vecs[k].data, i), cap[i], e);
      end
    end

    // Fill with the line stalled: 8 in FIFO + 1 in shifter
    acc_cnt = 0;
    repeat (12) step(1'b1, 8'($urandom), 1'b0);
    chk("fill_accepted", acc_cnt, 9);
    chk("fill_ready", tx_ready, 1'b0);
    chk("fill_count", fifo_count, 8);
    chk("fill_tx", tx, 1'b0);

    // Pop from a full FIFO with a push attempted on the same edge
    done_cnt = 0;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) step(1'b1, 8'($urandom), (cyc % 4) == 0);
    chk("full_pop_seen", done_cnt, 1);
    chk("full_pop_count", fifo_count, 7);
    chk("full_pop_ready", tx_ready, 1'b1);
    chk("full_pop_next_start", tx, 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    chk("push_after_pop", fifo_count, 8);
    apply_reset();

    // Reset during DATA bit 3 with 4 bytes queued
    repeat (5) step(1'b1, 8'($urandom), 1'b0);
    chk("queued4", fifo_count, 4);
    for (int n = 0; n < 3000 && !(m_active && m_bit == 4 && m_ticks >= 5); n++)
      step(1'b0, 8'h00, (cyc % 4) == 0);
    chk("pre_rst_count", fifo_count, 4);
    apply_reset();
    done_cnt = 0;
    repeat (300) step(1'b0, 8'h00, (cyc % 4) == 0);
    chk("no_resume_done", done_cnt, 0);

    // Back-to-back frames
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    done_cnt = 0;
    gaps     = 0;
    for (int n = 0; n < 6000 && done_cnt < 3; n++) begin
      step(1'b0, 8'h00, (cyc % 4) == 0);
      if (done_cnt < 3 && !busy) gaps++;
    end
    chk("b2b_frames", done_cnt, 3);
    chk("b2b_gaps", gaps, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("b2b_idle_tx", tx, 1'b1);
    chk("b2b_idle_busy", busy, 1'b0);

    // Random traffic
    for (int n = 0; n < 12000; n++)
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 1) == 1);
    for (int n = 0; n < 20000 && (m_active || exp_q.size() != 0); n++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("drain_busy", busy, 1'b0);
    chk("drain_count", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
